// File: rtl/sram_rgb_pkg.sv
// Shared types and helpers for the SRAM RGB line filter.
//  mode_t   : filter selection latched at frame start (3 behaves as pass-through)
//  state_t  : fetch sequencer states
//  rgb24_t  : one unpacked source pixel, 8 bits per channel
//  rgb30_t  : one output pixel, 10 bits per channel
//  expand10 : widen an 8-bit channel to the 10-bit output scale
//  avg10    : 2-tap average, 11-bit sum, truncated result
package sram_rgb_pkg;

  typedef enum logic [1:0] {
    MODE_PASS     = 2'd0,
    MODE_AVG2     = 2'd1,
    MODE_INTERP2X = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } rgb30_t;

  function automatic logic [9:0] expand10(input logic [7:0] v);
    return {v, 2'b00};
  endfunction

  function automatic logic [9:0] avg10(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[10:1];
  endfunction

  function automatic rgb30_t widen(input rgb24_t p);
    rgb30_t o;
    o.r = expand10(p.r);
    o.g = expand10(p.g);
    o.b = expand10(p.b);
    return o;
  endfunction

  function automatic rgb30_t avg_rgb(input rgb30_t a, input rgb30_t b);
    rgb30_t o;
    o.r = avg10(a.r, b.r);
    o.g = avg10(a.g, b.g);
    o.b = avg10(a.b, b.b);
    return o;
  endfunction

endpackage

// File: rtl/sram_rgb_line_filter_pixel_fifo.sv
// pixel_fifo: small synchronous first-word-fall-through FIFO for unpacked pixels.
//  clk_i, rst_ni     : clock, asynchronous active-low reset (pointers/count only)
//  push_i, din_i     : write strobe and data (ignored when full)
//  pop_i, dout_o     : read strobe (ignored when empty), head-of-queue data
//  full_o, empty_o   : status flags
//  count_o           : number of stored entries, 0..DEPTH
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  generate
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pixel_fifo DEPTH must be a power of 2 and >= 4");
    end
  endgenerate

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;
  // Head is read combinationally so the filter sees it in the same cycle it
  // decides to pop; the array is only a handful of entries deep.
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_rgb_line_filter.sv
// sram_rgb_line_filter: reads a packed 24-bit RGB frame from SRAM (3 words per
// 2 pixels) and streams one filtered 10-bit/channel pixel per valid/ready beat.
//  Clock, Resetn          : clock, asynchronous active-low reset
//  start, base_addr, mode : frame request; address and mode latched on accept
//  busy, done             : frame in progress / one-cycle completion pulse
//  SRAM_address, SRAM_we_n, SRAM_read_data : read-only SRAM port
//  pix_ready, pix_valid, pix_red/green/blue, pix_sol, pix_eof : pixel stream
module sram_rgb_line_filter
  import sram_rgb_pkg::*;
#(
  parameter int IMG_W           = 320,
  parameter int IMG_H           = 240,
  parameter int SRAM_RD_LATENCY = 2,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        start,
  input  logic [17:0] base_addr,
  input  logic [1:0]  mode,
  output logic        busy,
  output logic        done,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  input  logic        pix_ready,
  output logic        pix_valid,
  output logic [9:0]  pix_red,
  output logic [9:0]  pix_green,
  output logic [9:0]  pix_blue,
  output logic        pix_sol,
  output logic        pix_eof
);

  localparam int WORDS_PER_LINE = 3 * IMG_W / 2;
  localparam int TOTAL_WORDS    = IMG_H * WORDS_PER_LINE;
  localparam int WORD_W         = $clog2(TOTAL_WORDS + 1);
  localparam int COL_W          = $clog2(IMG_W);
  localparam int ROW_W          = $clog2(IMG_H + 1);
  localparam int CNT_W          = $clog2(FIFO_DEPTH) + 1;
  localparam int IF_W           = $clog2(SRAM_RD_LATENCY + 1) + 1;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(TOTAL_WORDS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_H - 1);

  generate
    if ((IMG_W % 2) != 0) begin : g_bad_width
      $error("IMG_W must be even");
    end
  endgenerate

  // ---------------- fetch sequencer ----------------
  state_t             state_q;
  logic               busy_q, done_q;
  logic [17:0]        addr_q;
  logic [WORD_W-1:0]  word_cnt_q;
  mode_t              mode_q;
  logic [IF_W-1:0]    inflight_q;
  logic               tag_q [SRAM_RD_LATENCY];

  logic               start_accept, issue, ret, credit_ok, eof_hs;
  logic [15:0]        free_w, need_w;
  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CNT_W-1:0]   fifo_count;
  logic [23:0]        fifo_din, fifo_dout;

  // A word may only be issued if the FIFO can absorb everything already in
  // flight plus this word, so a return never finds the FIFO full.
  assign free_w       = 16'(FIFO_DEPTH) - 16'(fifo_count);
  assign need_w       = 16'(inflight_q) + 16'd2;
  assign credit_ok    = (free_w >= need_w) && !fifo_full;
  assign start_accept = (state_q == S_IDLE) && start;
  assign issue        = (state_q == S_FETCH) && credit_ok;
  assign ret          = tag_q[SRAM_RD_LATENCY-1];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= '0;
      word_cnt_q <= '0;
      mode_q     <= MODE_PASS;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          busy_q     <= 1'b1;
          addr_q     <= base_addr;
          mode_q     <= mode_t'(mode);
          word_cnt_q <= '0;
          state_q    <= S_FETCH;
        end
        S_FETCH: if (issue) begin
          if (word_cnt_q == LAST_WORD) begin
            state_q <= S_DRAIN;
          end else begin
            addr_q     <= addr_q + 18'd1;
            word_cnt_q <= word_cnt_q + 1'b1;
          end
        end
        S_DRAIN: if (eof_hs) begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign SRAM_address = addr_q;
  assign SRAM_we_n    = 1'b1;

  // Outstanding-read count for the credit check.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      inflight_q <= '0;
    end else begin
      case ({issue, ret})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Valid tags travel alongside the SRAM pipeline; tag_q[LAT-1] marks the
  // cycle in which SRAM_read_data belongs to an issued address.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) tag_q[0] <= 1'b0;
    else         tag_q[0] <= issue;
  end

  generate
    for (genvar gi = 1; gi < SRAM_RD_LATENCY; gi++) begin : g_tag
      always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) tag_q[gi] <= 1'b0;
        else         tag_q[gi] <= tag_q[gi-1];
      end
    end
  endgenerate

  // ---------------- unpacker ----------------
  // W0={R0,G0} W1={B0,R1} W2={G1,B1}: pixel 0 completes on W1, pixel 1 on W2.
  logic [1:0]  phase_q;
  logic [15:0] w0_q;
  logic [7:0]  r1_q;

  assign fifo_push = ret && (phase_q != 2'd0);
  assign fifo_din  = (phase_q == 2'd1) ? {w0_q, SRAM_read_data[15:8]}
                                       : {r1_q, SRAM_read_data};

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      phase_q <= 2'd0;
      w0_q    <= '0;
      r1_q    <= '0;
    end else if (start_accept) begin
      phase_q <= 2'd0;
    end else if (ret) begin
      case (phase_q)
        2'd0:    begin w0_q <= SRAM_read_data; phase_q <= 2'd1; end
        2'd1:    begin r1_q <= SRAM_read_data[7:0]; phase_q <= 2'd2; end
        default: phase_q <= 2'd0;
      endcase
    end
  end

  pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(24)) u_fifo (
    .clk_i   (Clock),
    .rst_ni  (Resetn),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ---------------- filter / output register ----------------
  logic [COL_W-1:0] in_col_q;
  logic [ROW_W-1:0] in_row_q;
  logic [1:0]       step_q;
  rgb24_t           prev_q;
  rgb30_t           pix_q;
  logic             pix_valid_q, pix_sol_q, pix_eof_q;

  rgb24_t head;
  rgb30_t head10, blend, emit_d;
  logic   col_first, col_last, row_last, last_step, sol_d, eof_d, load, take;

  assign head      = rgb24_t'(fifo_dout);
  assign head10    = widen(head);
  assign blend     = avg_rgb(widen(prev_q), head10);
  assign col_first = (in_col_q == '0);
  assign col_last  = (in_col_q == LAST_COL);
  assign row_last  = (in_row_q == LAST_ROW);

  // Interpolation expands source pixel k>0 into avg(k-1,k) then k; the last
  // source pixel of a line gets a third step that repeats it.
  always_comb begin
    emit_d    = head10;
    last_step = 1'b1;
    sol_d     = col_first;
    eof_d     = col_last && row_last;
    case (mode_q)
      MODE_AVG2: if (!col_first) emit_d = blend;
      MODE_INTERP2X: if (!col_first) begin
        case (step_q)
          2'd0: begin emit_d = blend; last_step = 1'b0; eof_d = 1'b0; end
          2'd1: begin last_step = !col_last; eof_d = 1'b0; end
          default: eof_d = row_last;
        endcase
      end
      default: ;
    endcase
  end

  assign load     = !pix_valid_q || pix_ready;
  assign take     = load && !fifo_empty;
  assign fifo_pop = take && last_step;
  assign eof_hs   = pix_valid_q && pix_ready && pix_eof_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pix_valid_q <= 1'b0;
      pix_sol_q   <= 1'b0;
      pix_eof_q   <= 1'b0;
      pix_q       <= '0;
      in_col_q    <= '0;
      in_row_q    <= '0;
      step_q      <= '0;
      prev_q      <= '0;
    end else if (start_accept) begin
      in_col_q <= '0;
      in_row_q <= '0;
      step_q   <= '0;
      prev_q   <= '0;
    end else if (load) begin
      pix_valid_q <= !fifo_empty;
      if (take) begin
        pix_q     <= emit_d;
        pix_sol_q <= sol_d;
        pix_eof_q <= eof_d;
        if (last_step) begin
          step_q <= '0;
          if (col_last) begin
            in_col_q <= '0;
            prev_q   <= '0;
            in_row_q <= row_last ? '0 : in_row_q + 1'b1;
          end else begin
            in_col_q <= in_col_q + 1'b1;
            prev_q   <= head;
          end
        end else begin
          step_q <= step_q + 2'd1;
        end
      end else begin
        pix_sol_q <= 1'b0;
        pix_eof_q <= 1'b0;
      end
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_red   = pix_q.r;
  assign pix_green = pix_q.g;
  assign pix_blue  = pix_q.b;
  assign pix_sol   = pix_sol_q;
  assign pix_eof   = pix_eof_q;

endmodule

// File: tb/tb_sram_rgb_line_filter.sv
module tb_sram_rgb_line_filter;

  localparam int W     = 8;
  localparam int H     = 3;
  localparam int LAT   = 3;
  localparam int DEPTH = 8;
  localparam int WPL   = 3 * W / 2;
  localparam int TOT   = H * WPL;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        start = 1'b0;
  logic [17:0] base_addr = '0;
  logic [1:0]  mode = '0;
  logic        busy, done, SRAM_we_n, pix_valid, pix_sol, pix_eof;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic        pix_ready = 1'b0;
  logic [9:0]  pix_red, pix_green, pix_blue;

  sram_rgb_line_filter #(
    .IMG_W(W), .IMG_H(H), .SRAM_RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .start(start), .base_addr(base_addr), .mode(mode),
    .busy(busy), .done(done), .SRAM_address(SRAM_address), .SRAM_we_n(SRAM_we_n),
    .SRAM_read_data(SRAM_read_data), .pix_ready(pix_ready), .pix_valid(pix_valid),
    .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue),
    .pix_sol(pix_sol), .pix_eof(pix_eof)
  );

  always #10 Clock = ~Clock;

  // SRAM model: data for the address presented in cycle t appears in cycle t+LAT.
  logic [15:0] mem [1024];
  logic [17:0] pipe [LAT];
  always @(posedge Clock) begin
    pipe[0] <= SRAM_address;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign SRAM_read_data = mem[pipe[LAT-1][9:0]];

  typedef struct {
    logic [9:0] r, g, b;
    logic sol, eof;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0, hs_count = 0, ready_mode = 0;
  bit addr_bad = 0;
  logic [17:0] cur_base = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [9:0] mavg(input logic [9:0] a, input logic [9:0] b);
    int s;
    s = (int'(a) + int'(b)) / 2;
    return 10'(s);
  endfunction

  // Reference: unpack each line into 10-bit channels, then apply the
  // per-line output formula for the selected mode.
  task automatic build_expected(input logic [17:0] b, input logic [1:0] md);
    logic [9:0] pin [3][W];
    logic [9:0] v [3];
    logic [15:0] w0, w1, w2;
    int wa, n, k;
    exp_t e;
    for (int L = 0; L < H; L++) begin
      for (int c = 0; c < W; c++) begin
        wa = int'(b) + L * WPL + 3 * (c / 2);
        w0 = mem[wa % 1024];
        w1 = mem[(wa + 1) % 1024];
        w2 = mem[(wa + 2) % 1024];
        if (c % 2 == 0) begin
          pin[0][c] = {w0[15:8], 2'b00};
          pin[1][c] = {w0[7:0], 2'b00};
          pin[2][c] = {w1[15:8], 2'b00};
        end else begin
          pin[0][c] = {w1[7:0], 2'b00};
          pin[1][c] = {w2[15:8], 2'b00};
          pin[2][c] = {w2[7:0], 2'b00};
        end
      end
      n = (md == 2'd2) ? 2 * W : W;
      for (int o = 0; o < n; o++) begin
        for (int ch = 0; ch < 3; ch++) begin
          if (md == 2'd1) begin
            v[ch] = (o == 0) ? pin[ch][0] : mavg(pin[ch][o-1], pin[ch][o]);
          end else if (md == 2'd2) begin
            k = o / 2;
            if (o % 2 == 0)  v[ch] = pin[ch][k];
            else if (k < W-1) v[ch] = mavg(pin[ch][k], pin[ch][k+1]);
            else              v[ch] = pin[ch][W-1];
          end else begin
            v[ch] = pin[ch][o];
          end
        end
        e.r = v[0]; e.g = v[1]; e.b = v[2];
        e.sol = (o == 0);
        e.eof = (L == H-1) && (o == n-1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Downstream ready patterns: always, alternate, mostly-ready, coin flip.
  initial begin
    forever begin
      @(posedge Clock);
      #1;
      case (ready_mode)
        0: pix_ready = 1'b1;
        1: pix_ready = ~pix_ready;
        2: pix_ready = ($urandom_range(0, 3) != 0);
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares every handshake against the scoreboard, checks that a
  // stalled pixel is held, and that done follows the eof handshake.
  initial begin
    bit expect_done, stall_q;
    logic [31:0] held, cur;
    exp_t e;
    expect_done = 0;
    stall_q = 0;
    held = '0;
    forever begin
      @(negedge Clock);
      if (!Resetn) begin
        expect_done = 0;
        stall_q = 0;
      end else begin
        cur = {pix_red, pix_green, pix_blue, pix_sol, pix_eof};
        if (expect_done) begin
          chk("done_after_eof", 64'(done), 64'd1);
          expect_done = 0;
        end else if (done) begin
          chk("done_spurious", 64'(done), 64'd0);
        end
        if (stall_q) chk("stall_hold", {31'd0, pix_valid, cur}, {31'd0, 1'b1, held});
        if (pix_valid && pix_ready) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            chk("unexpected_pixel", 64'(cur), 64'hFFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("pixel", 64'(cur), 64'({e.r, e.g, e.b, e.sol, e.eof}));
          end
          if (pix_eof) expect_done = 1;
        end
        stall_q = pix_valid && !pix_ready;
        held = cur;
        if (busy && (SRAM_address < cur_base || SRAM_address >= cur_base + 18'(TOT) || !SRAM_we_n))
          addr_bad = 1;
      end
    end
  end

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
  endtask

  task automatic issue_start(input logic [17:0] b, input logic [1:0] md);
    @(posedge Clock);
    #1;
    base_addr = b;
    mode = md;
    start = 1'b1;
    @(posedge Clock);
    #1;
    start = 1'b0;
    base_addr = 18'($urandom);
    mode = 2'($urandom);
  endtask

  task automatic run_frame(input logic [17:0] b, input logic [1:0] md, input int rmode,
                           input bit restart_mid, input bit start_on_done);
    int n, lim;
    fill_mem();
    ready_mode = rmode;
    cur_base = b;
    addr_bad = 0;
    hs_count = 0;
    build_expected(b, md);
    issue_start(b, md);
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!pix_valid && n < 200);
    lim = LAT + 4 + ((md == 2'd2) ? 1 : 0);
    checks++;
    if (n > lim) begin
      errors++;
      $display("FAIL first_valid_latency: %0d cycles, limit %0d", n, lim);
    end
    if (restart_mid) issue_start(18'h000, md ^ 2'd1);
    n = 0;
    while (!done && n < 5000) begin
      @(negedge Clock);
      n++;
    end
    chk("done_seen", 64'(done), 64'd1);
    chk("busy_low_at_done", 64'(busy), 64'd0);
    chk("all_pixels_seen", 64'(exp_q.size()), 64'd0);
    chk("addr_in_range", 64'(addr_bad), 64'd0);
    if (start_on_done) begin
      start = 1'b1;
      base_addr = b;
      @(posedge Clock);
      #1;
      start = 1'b0;
      @(negedge Clock);
      chk("start_on_done_ignored", 64'(busy), 64'd0);
    end
    exp_q.delete();
  endtask

  initial begin
    int n;
    repeat (3) @(posedge Clock);
    #5;
    chk("reset_ctrl", 64'({busy, done, pix_valid, pix_sol, pix_eof}), 64'd0);
    chk("reset_colour", 64'({pix_red, pix_green, pix_blue}), 64'd0);
    chk("reset_sram", 64'({SRAM_address, SRAM_we_n}), 64'd1);
    Resetn = 1'b1;

    run_frame(18'd16,  2'd0, 0, 0, 0);
    run_frame(18'd40,  2'd1, 0, 0, 0);
    run_frame(18'd7,   2'd2, 1, 0, 0);
    run_frame(18'd500, 2'd3, 2, 0, 0);
    run_frame(18'd90,  2'd1, 3, 0, 1);
    run_frame(18'h100, 2'd0, 2, 1, 0);
    run_frame(18'd300, 2'd2, 2, 0, 0);

    // Abort a frame part-way with an asynchronous reset.
    fill_mem();
    ready_mode = 0;
    cur_base = 18'd200;
    hs_count = 0;
    build_expected(18'd200, 2'd1);
    issue_start(18'd200, 2'd1);
    n = 0;
    while (hs_count < 10 && n < 2000) begin
      @(negedge Clock);
      n++;
    end
    chk("reached_mid_frame", 64'(hs_count >= 10), 64'd1);
    #3;
    Resetn = 1'b0;
    #1;
    chk("async_reset_ctrl", 64'({busy, done, pix_valid, pix_sol, pix_eof}), 64'd0);
    chk("async_reset_colour", 64'({pix_red, pix_green, pix_blue}), 64'd0);
    chk("async_reset_sram", 64'({SRAM_address, SRAM_we_n}), 64'd1);
    exp_q.delete();
    repeat (2) @(posedge Clock);
    #3;
    Resetn = 1'b1;
    run_frame(18'd33, 2'd0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
